// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the result-to-BCD display converter:
// FSM state encoding and the BCD digit constants.
package result_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/result_bcd_converter_if.sv
// Request/result bundle between the adder/subtractor side (master)
// and the BCD converter (slave).
interface result_bcd_converter_if
    import result_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) ();

    logic                          start;
    logic [WIDTH-1:0]              result;
    logic                          overflow;
    logic                          signed_mode;
    logic                          busy;
    logic                          done;
    logic                          sign;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic                          ovf_out;

    modport master (
        output start, result, overflow, signed_mode,
        input  busy, done, sign, bcd, ovf_out
    );

    modport slave (
        input  start, result, overflow, signed_mode,
        output busy, done, sign, bcd, ovf_out
    );

endinterface

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module result_bcd_converter_bcd_add3
    import result_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    assign d_o = (d_i >= ADD3_THRESH) ? d_i + BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// sign handling and held outputs for the 7-segment driver.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    result_bcd_converter_if.slave  bus
);

    localparam int               BCD_W     = BCD_DIGIT_W * DIGITS;
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0] scr_q, scr_d;
    logic [BCD_W-1:0] scr_corr;
    logic [BCD_W-1:0] scr_shift;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovf_cap_q, ovf_cap_d;
    logic             sign_q, sign_d;
    logic             ovf_out_q, ovf_out_d;
    logic             in_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        result_bcd_converter_bcd_add3 u_add3 (
            .d_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (scr_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign in_neg    = bus.signed_mode & bus.result[WIDTH-1];
    assign scr_shift = {scr_corr[BCD_W-2:0], mag_q[WIDTH-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            scr_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_cap_q <= 1'b0;
            sign_q    <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            scr_q     <= scr_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_cap_q <= ovf_cap_d;
            sign_q    <= sign_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        scr_d     = scr_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_cap_d = ovf_cap_q;
        sign_d    = sign_q;
        ovf_out_d = ovf_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // 0x8000 negates to itself, which is exactly 32768 as unsigned
                    mag_d     = in_neg ? (~bus.result + WIDTH'(1)) : bus.result;
                    neg_d     = in_neg;
                    ovf_cap_d = bus.overflow;
                    scr_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d = scr_shift;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                if (cnt_q == LAST_ITER) begin
                    // Outputs change only here, so the display never sees a partial word
                    bcd_d     = scr_shift;
                    sign_d    = neg_q;
                    ovf_out_d = ovf_cap_q;
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.sign    = sign_q;
    assign bus.bcd     = bcd_q;
    assign bus.ovf_out = ovf_out_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: directed corner cases plus
// random conversions checked against a decimal-arithmetic reference model.
module tb_result_bcd_converter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

    result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          cyc       = 0;
    int          last_done = -1;
    int          done_gap  = 0;
    logic [19:0] last_bcd  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: magnitude from plain integer arithmetic, digits by repeated /10
    function automatic void push(input logic [15:0] r, input logic sm, input logic ov);
        exp_t        e;
        int unsigned v;
        logic        neg;
        neg = sm & r[15];
        v   = neg ? (32'd65536 - 32'(r)) : 32'(r);
        e.bcd = '0;
        for (int i = 0; i < 5; i++) begin
            e.bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.sign = neg;
        e.ovf  = ov;
        e.cyc  = cyc;
        q.push_back(e);
    endfunction

    // Monitor: pops one expectation per done pulse; checks hold while busy
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, expected no pending conversion (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("bcd", 32'(bus.bcd), 32'(e.bcd));
                    check("sign", 32'(bus.sign), 32'(e.sign));
                    check("ovf_out", 32'(bus.ovf_out), 32'(e.ovf));
                    check("latency", cyc - e.cyc, 17);
                    done_gap  = cyc - last_done;
                    last_done = cyc;
                    last_bcd  = e.bcd;
                end
            end else if (bus.busy) begin
                check("hold_bcd", 32'(bus.bcd), 32'(last_bcd));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic convert(input logic [15:0] r, input logic sm, input logic ov);
        wait_idle();
        bus.result      = r;
        bus.signed_mode = sm;
        bus.overflow    = ov;
        bus.start       = 1'b1;
        push(r, sm, ov);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        bus.start       = 1'b0;
        bus.result      = '0;
        bus.overflow    = 1'b0;
        bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sign", 32'(bus.sign), 0);
        check("rst_bcd", 32'(bus.bcd), 0);
        check("rst_ovf", 32'(bus.ovf_out), 0);
        rst = 1'b1;
        @(negedge clk);

        convert(16'h0000, 1'b0, 1'b0);
        convert(16'hFFFF, 1'b0, 1'b0);
        convert(16'hFFFF, 1'b1, 1'b0);
        convert(16'h8000, 1'b1, 1'b1);
        convert(16'h7FFF, 1'b1, 1'b0);
        drain();

        // Extra start pulses mid-conversion must be ignored
        wait_idle();
        bus.result      = 16'd4321;
        bus.signed_mode = 1'b0;
        bus.overflow    = 1'b0;
        bus.start       = 1'b1;
        push(16'd4321, 1'b0, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = (k == 3 || k == 16);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
        end
        check("busy_cycles", busy_cnt, 17);
        check("done_count", done_cnt, 1);
        drain();

        // Reset in the middle of a conversion
        convert(16'hABCD, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_bcd", 32'(bus.bcd), 0);
        check("midrst_sign", 32'(bus.sign), 0);
        check("midrst_ovf", 32'(bus.ovf_out), 0);
        q.delete();
        last_bcd = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        convert(16'h3039, 1'b0, 1'b0);
        drain();

        // Back-to-back with start held high
        wait_idle();
        bus.result      = 16'd1;
        bus.signed_mode = 1'b0;
        bus.overflow    = 1'b0;
        bus.start       = 1'b1;
        push(16'd1, 1'b0, 1'b0);
        @(negedge clk);
        bus.result = 16'd9999;
        wait_idle();
        push(16'd9999, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        check("b2b_gap", done_gap, 18);

        for (int i = 0; i < 30; i++) begin
            convert(16'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
